// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer-type encodings and the command record
// used by the master and by slave-side benches.
package ahb_pkg;

    localparam int AHB_ADDR_W = 8;
    localparam int AHB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        NONSEQ = 2'b10
    } htrans_t;

    typedef struct packed {
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_cmd_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; the head word is presented
// combinationally so the master can load it into the address phase on pop.
module ahb_cmd_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap without compare logic.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ahb_master.sv
// AHB-Lite single-transfer master: queued commands are issued as NONSEQ
// transfers through a two-stage address/data pipeline stalled by hready.
module ahb_master
    import ahb_pkg::*;
#(
    parameter int addrWidth = AHB_ADDR_W,
    parameter int dataWidth = AHB_DATA_W,
    parameter int cmdDepth  = 4
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 hselx,
    output logic [1:0]           htrans,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata
);

    localparam int CMD_W = 1 + addrWidth + dataWidth;

    logic [CMD_W-1:0]     fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 head_write;
    logic [addrWidth-1:0] head_addr;
    logic [dataWidth-1:0] head_wdata;
    logic [dataWidth-1:0] wdata_p0;
    logic                 vld_p1;
    logic                 write_p1;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = hready && !fifo_empty;
    assign {head_write, head_addr, head_wdata} = fifo_dout;

    ahb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (cmdDepth)
    ) u_cmd_fifo (
        .hclk    (hclk),
        .hresetn (hresetn),
        .push    (cmd_valid),
        .din     ({cmd_write, cmd_addr, cmd_wdata}),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // htrans/haddr/hwrite form the address phase (_p0); the data phase (_p1)
    // tracks the transfer whose hwdata/hrdata is on the bus this cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            htrans    <= IDLE;
            hselx     <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            wdata_p0  <= '0;
            hwdata    <= '0;
            vld_p1    <= 1'b0;
            write_p1  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (hready) begin
                // Data phase completes: report it.
                if (vld_p1) begin
                    rsp_valid <= 1'b1;
                    rsp_write <= write_p1;
                    rsp_rdata <= write_p1 ? '0 : hrdata;
                end
                // Address phase -> data phase.
                vld_p1   <= (htrans == NONSEQ);
                write_p1 <= hwrite;
                if (htrans == NONSEQ && hwrite) hwdata <= wdata_p0;
                // FIFO head -> address phase.
                if (!fifo_empty) begin
                    htrans   <= NONSEQ;
                    hselx    <= 1'b1;
                    haddr    <= head_addr;
                    hwrite   <= head_write;
                    wdata_p0 <= head_wdata;
                end else begin
                    htrans <= IDLE;
                    hselx  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Scoreboarded bench for ahb_master: a memory slave answers the bus, and
// responses are checked in command order against a reference memory.
module tb_ahb_master;
    import ahb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          hselx;
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic [DW-1:0] hrdata;

    int            checks = 0;
    int            errors = 0;
    int            rsp_cnt = 0;
    int            base;
    logic [DW-1:0] last_rdata;
    logic          rand_on;
    ahb_cmd_t      exp_q[$];
    ahb_cmd_t      mon_c;
    bit [DW-1:0]   ref_mem [256];
    bit [DW-1:0]   smem [256];

    logic          sl_vld;
    logic          sl_wr;
    logic [AW-1:0] sl_addr;

    always #5 hclk = ~hclk;

    ahb_master #(
        .addrWidth (AW),
        .dataWidth (DW),
        .cmdDepth  (4)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .hselx     (hselx),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata)
    );

    // Memory slave: latches the address phase, commits writes when the data phase completes.
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sl_vld  <= 1'b0;
            sl_wr   <= 1'b0;
            sl_addr <= '0;
        end else if (hready) begin
            if (sl_vld && sl_wr) smem[sl_addr] <= hwdata;
            sl_vld  <= hselx && (htrans == 2'b10);
            sl_wr   <= hwrite;
            sl_addr <= haddr;
        end
    end

    assign hrdata = (sl_vld && !sl_wr) ? smem[sl_addr] : 32'hA5A5_5A5A;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ahb_cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        exp_q.push_back(c);
    endtask

    // Called at a negedge; leaves cmd_valid high so consecutive calls are back-to-back.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge hclk);
            n++;
        end
        if (n == 100) begin
            check("send_timeout", 128'(cmd_ready), 128'(1));
            cmd_valid = 1'b0;
        end else begin
            exp_push(w, a, d);
            @(negedge hclk);
        end
    endtask

    task automatic cmd_idle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge hclk);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge hclk);
    endtask

    initial begin
        hresetn   = 1'b0;
        hready    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rand_on   = 1'b0;

        fork
            begin
                #300000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
            forever begin
                @(negedge hclk);
                if (hresetn && rsp_valid) begin
                    rsp_cnt++;
                    last_rdata = rsp_rdata;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 128'(rsp_valid), 128'(0));
                    end else begin
                        mon_c = exp_q.pop_front();
                        check("rsp_write", 128'(rsp_write), 128'(mon_c.write));
                        if (mon_c.write) begin
                            check("rsp_rdata_wr", 128'(rsp_rdata), 128'(0));
                            ref_mem[mon_c.addr] = mon_c.wdata;
                        end else begin
                            check("rsp_rdata", 128'(rsp_rdata), 128'(ref_mem[mon_c.addr]));
                        end
                    end
                end
            end
        join_none

        // Reset values, then no transfer while hready has not yet been seen high.
        repeat (3) @(negedge hclk);
        check("rst_outs", 128'({htrans, hselx, haddr, hwrite, hwdata, rsp_valid, rsp_write, rsp_rdata}), 128'(0));
        hresetn = 1'b1;
        @(negedge hclk);
        check("rst_ready", 128'(cmd_ready), 128'(1));
        send(1'b0, 8'h33, 32'h0);
        cmd_idle();
        repeat (3) begin
            @(negedge hclk);
            check("hold_until_hready", 128'(htrans), 128'(2'b00));
        end
        hready = 1'b1;
        drain();

        // Single write latency, then read-back of the same address.
        base = rsp_cnt;
        send(1'b1, 8'h10, 32'hDEAD_BEEF);
        cmd_idle();
        check("lat_n", 128'(htrans), 128'(2'b00));
        @(negedge hclk);
        check("lat_ap", 128'({htrans, haddr, hwrite}), 128'({2'b10, 8'h10, 1'b1}));
        @(negedge hclk);
        check("lat_dp", 128'({htrans, hwdata}), 128'({2'b00, 32'hDEAD_BEEF}));
        @(negedge hclk);
        check("lat_rsp", 128'({rsp_valid, rsp_write}), 128'(2'b11));
        send(1'b0, 8'h10, 32'h0);
        cmd_idle();
        drain();
        check("wr_rd_rsp_count", 128'(rsp_cnt - base), 128'(2));
        check("rd_deadbeef", 128'(last_rdata), 128'(32'hDEAD_BEEF));

        // Four queued writes issued on consecutive cycles.
        hready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 32'((i + 1) * 17));
        cmd_idle();
        check("full_ready", 128'(cmd_ready), 128'(0));
        hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            check("b2b_ap", 128'({htrans, haddr}), 128'({2'b10, 8'(i)}));
            if (i > 0) check("b2b_hwdata", 128'(hwdata), 128'(32'(i * 17)));
        end
        @(negedge hclk);
        check("b2b_tail", 128'({htrans, hwdata}), 128'({2'b00, 32'h44}));
        drain();

        // Wait states during a read address phase.
        send(1'b0, 8'h20, 32'h0);
        cmd_idle();
        @(negedge hclk);
        check("ws_ap", 128'({htrans, haddr}), 128'({2'b10, 8'h20}));
        base = rsp_cnt;
        hready = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            check("ws_hold", 128'({htrans, haddr, rsp_valid}), 128'({2'b10, 8'h20, 1'b0}));
        end
        hready = 1'b1;
        repeat (6) @(negedge hclk);
        check("ws_one_rsp", 128'(rsp_cnt - base), 128'(1));
        drain();

        // Fifth command waits until the first one pops.
        hready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h40 + i), $urandom);
        cmd_idle();
        check("q_full", 128'(cmd_ready), 128'(0));
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h41;
        cmd_wdata = 32'h0;
        repeat (2) begin
            @(negedge hclk);
            check("q_5th_blocked", 128'(cmd_ready), 128'(0));
        end
        hready = 1'b1;
        @(negedge hclk);
        check("q_5th_ready", 128'(cmd_ready), 128'(1));
        exp_push(1'b0, 8'h41, 32'h0);
        @(negedge hclk);
        cmd_idle();
        drain();

        // Reset in the middle of three writes.
        base = rsp_cnt;
        for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h50 + i), 32'(i + 1));
        hresetn = 1'b0;
        #1;
        check("rst_mid", 128'({htrans, hselx, haddr, hwrite, hwdata, rsp_valid, rsp_write, rsp_rdata}), 128'(0));
        cmd_idle();
        exp_q.delete();
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        check("rst_rel_ready", 128'(cmd_ready), 128'(1));
        repeat (6) @(negedge hclk);
        check("rst_no_rsp", 128'(rsp_cnt - base), 128'(0));

        // Random traffic with random wait states.
        rand_on = 1'b1;
        fork
            forever begin
                @(negedge hclk);
                if (!rand_on) break;
                hready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int k = 0; k < 300; k++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                cmd_idle();
                repeat ($urandom_range(1, 3)) @(negedge hclk);
            end
        end
        cmd_idle();
        rand_on = 1'b0;
        @(negedge hclk);
        hready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
